prog_loader: RTL and testbench

Boot-time program loader for the 5-stage RISC-V core. It takes a stream of words over a valid/ready handshake and writes them into one of NUM_BANKS memories (bank 0 = Inst_mem, bank 1 = Data_mem) at consecutive word addresses. It holds the CPU pipeline in reset until the load completes, then releases it after a programmable hold time. This block replaces the ad-hoc address mux and write loop used during bring-up with a reusable, checked path.

---
 rtl/prog_loader_pkg.sv | 22 ++
 rtl/prog_loader_if.sv | 26 ++
 rtl/prog_loader_addr_gen.sv | 29 ++
 rtl/prog_loader.sv | 122 ++++++++++++
 tb/tb_prog_loader.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM encoding,
// bank indices and a constant-width helper.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam int BANK_INST = 0;
  localparam int BANK_DATA = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Stream input and memory write bus of the program loader, grouped so the
// loader and its environment connect through one port.
interface prog_loader_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int NUM_BANKS = 2
);

  logic                 s_valid;
  logic [DATA_W-1:0]    s_data;
  logic                 s_ready;
  logic [NUM_BANKS-1:0] mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_wdata;

  modport master (
    output s_valid, s_data,
    input  s_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/prog_loader_addr_gen.sv
// Word index counter and byte-address generator; kept separate so a future
// readback/verify pass can walk the same address sequence.
module ldr_addr_gen #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                CNT_W     = 9,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              inc,
  output logic [CNT_W-1:0]  idx,
  output logic [ADDR_W-1:0] byte_addr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + CNT_W'(1);
    end
  end

  assign byte_addr = BASE_ADDR + ADDR_W'(idx) * ADDR_W'(DATA_W / 8);

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: streams words into one of NUM_BANKS memories and
// keeps the CPU in reset until the load and a hold period have completed.
module prog_loader
  import loader_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH       = 256,
  parameter int                NUM_BANKS   = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                HOLD_CYCLES = 2,
  localparam int               CNT_W       = clog2(DEPTH + 1),
  localparam int               SEL_W       = (NUM_BANKS > 1) ? clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SEL_W-1:0]  bank_sel,
  input  logic [CNT_W-1:0]  word_cnt,
  prog_loader_if.slave      bus,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum
);

  localparam int HOLD_W = clog2(HOLD_CYCLES + 1);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    bank_q;
  logic [CNT_W-1:0]    count_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [CNT_W-1:0]    idx;
  logic [ADDR_W-1:0]   byte_addr;
  logic                args_ok, start_ok, start_bad;
  logic                accept, last_accept, hold_done;

  ldr_addr_gen #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .CNT_W    (CNT_W),
    .BASE_ADDR(BASE_ADDR)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_ok),
    .inc      (accept),
    .idx      (idx),
    .byte_addr(byte_addr)
  );

  assign bus.s_ready  = (state_q == LOAD) && (idx < count_q);
  assign accept       = bus.s_ready && bus.s_valid;
  assign last_accept  = accept && (idx == count_q - CNT_W'(1));
  assign hold_done    = (hold_q == HOLD_W'(HOLD_CYCLES));
  assign busy         = (state_q == LOAD) || (state_q == HOLD);
  assign done         = (state_q == RUN);
  assign cpu_rst_n    = (state_q == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Start is only honoured while idle or running; a load or hold in progress ignores it.
  always_comb begin
    args_ok   = (word_cnt != '0) && (int'(word_cnt) <= DEPTH) && (int'(bank_sel) < NUM_BANKS);
    start_ok  = 1'b0;
    start_bad = 1'b0;
    state_d   = state_q;
    unique case (state_q)
      IDLE, RUN: begin
        start_ok  = start && args_ok;
        start_bad = start && !args_ok;
        if (start_ok) state_d = LOAD;
      end
      LOAD: begin
        if (last_accept) state_d = HOLD;
      end
      HOLD: begin
        if (hold_done) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Each accepted word becomes a registered write on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q        <= '0;
      count_q       <= '0;
      hold_q        <= '0;
      err           <= 1'b0;
      checksum      <= '0;
      bus.mem_we    <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_we <= '0;
      if (start_ok) begin
        bank_q   <= bank_sel;
        count_q  <= word_cnt;
        checksum <= '0;
        err      <= 1'b0;
      end else if (start_bad) begin
        err <= 1'b1;
      end
      if (accept) begin
        checksum      <= checksum + bus.s_data;
        bus.mem_we    <= NUM_BANKS'(1) << bank_q;
        bus.mem_addr  <= byte_addr;
        bus.mem_wdata <= bus.s_data;
      end
      hold_q <= ((state_q == HOLD) && !hold_done) ? hold_q + HOLD_W'(1) : '0;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: loads, bubbles, rejects,
// reload from RUN, full depth with an ignored start, and asynchronous reset.
module tb_prog_loader;
  import loader_pkg::*;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 32;
  localparam int DEPTH       = 256;
  localparam int NUM_BANKS   = 2;
  localparam int HOLD_CYCLES = 2;
  localparam int CNT_W       = 9;
  localparam int SEL_W       = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [SEL_W-1:0]  bank_sel = '0;
  logic [CNT_W-1:0]  word_cnt = '0;
  logic              cpu_rst_n, busy, done, err;
  logic [DATA_W-1:0] checksum;

  logic [DATA_W-1:0] words [DEPTH];
  logic [DATA_W-1:0] exp_sum;
  int                compare_count = 0;
  int                mismatch_count = 0;

  prog_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANKS(NUM_BANKS)) bus_if ();

  prog_loader #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .DEPTH      (DEPTH),
    .NUM_BANKS  (NUM_BANKS),
    .BASE_ADDR  ('0),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bank_sel (bank_sel),
    .word_cnt (word_cnt),
    .bus      (bus_if),
    .cpu_rst_n(cpu_rst_n),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compare_count++;
    if (got !== exp) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_s_ready"},   bus_if.s_ready, 0);
    checkOutput({pfx, "_mem_we"},    bus_if.mem_we, 0);
    checkOutput({pfx, "_mem_addr"},  bus_if.mem_addr, 0);
    checkOutput({pfx, "_mem_wdata"}, bus_if.mem_wdata, 0);
    checkOutput({pfx, "_cpu_rst_n"}, cpu_rst_n, 0);
    checkOutput({pfx, "_busy"},      busy, 0);
    checkOutput({pfx, "_done"},      done, 0);
    checkOutput({pfx, "_err"},       err, 0);
    checkOutput({pfx, "_checksum"},  checksum, 0);
  endtask

  // Pulse start for one cycle; returns one cycle after the sampling edge.
  task automatic applyStimulus(input int bank, input int cnt);
    start    = 1'b1;
    bank_sel = SEL_W'(bank);
    word_cnt = CNT_W'(cnt);
    step();
    start = 1'b0;
  endtask

  // Streams words[0..n-1]; bit c of pattern gives s_valid on cycle c (pattern repeats
  // every pat_len cycles, pat_len=0 means always valid). Writes are checked the cycle after each accept.
  task automatic streamWords(input int bank, input int n, input logic [31:0] pattern,
                             input int pat_len, input bit mid_start);
    int  k = 0;
    int  cyc = 0;
    bit  v;
    exp_sum = '0;
    while (k < n && cyc < 4 * DEPTH) begin
      v = (pat_len == 0) ? 1'b1 : pattern[cyc % pat_len];
      bus_if.s_valid = v;
      bus_if.s_data  = v ? words[k] : 32'hDEAD_BEEF;
      start = mid_start && (cyc == n / 2);
      checkOutput("s_ready_load", bus_if.s_ready, 1);
      step();
      start = 1'b0;
      if (v) begin
        checkOutput("mem_we",    bus_if.mem_we, 64'(1) << bank);
        checkOutput("mem_addr",  bus_if.mem_addr, k * 4);
        checkOutput("mem_wdata", bus_if.mem_wdata, words[k]);
        exp_sum += words[k];
        k++;
      end else begin
        checkOutput("mem_we_bubble", bus_if.mem_we, 0);
      end
      cyc++;
    end
    checkOutput("stream_words_accepted", k, n);
    bus_if.s_valid = 1'b0;
    checkOutput("s_ready_after_last", bus_if.s_ready, 0);
    checkOutput("checksum", checksum, exp_sum);
  endtask

  // Called in the first HOLD cycle; walks the hold period into RUN.
  task automatic holdToRun();
    checkOutput("hold_busy", busy, 1);
    checkOutput("hold_cpu_rst_n", cpu_rst_n, 0);
    for (int h = 0; h < HOLD_CYCLES; h++) begin
      step();
      checkOutput("hold_mem_we", bus_if.mem_we, 0);
      checkOutput("hold_cpu_rst_n", cpu_rst_n, 0);
      checkOutput("hold_done", done, 0);
    end
    step();
    checkOutput("run_cpu_rst_n", cpu_rst_n, 1);
    checkOutput("run_done", done, 1);
    checkOutput("run_busy", busy, 0);
  endtask

  initial begin
    bus_if.s_valid = 1'b0;
    bus_if.s_data  = '0;
    step();
    step();
    checkAllZero("reset");
    rst = 1'b0;
    step();
    checkAllZero("idle");

    // Rejects from IDLE
    applyStimulus(BANK_INST, 0);
    checkOutput("rej0_err", err, 1);
    checkOutput("rej0_busy", busy, 0);
    checkOutput("rej0_mem_we", bus_if.mem_we, 0);
    checkOutput("rej0_s_ready", bus_if.s_ready, 0);
    applyStimulus(BANK_INST, 257);
    checkOutput("rej257_err", err, 1);
    checkOutput("rej257_busy", busy, 0);

    // Basic instruction load; checksum 0x0081036C
    words[0] = 32'h0050_0093;
    words[1] = 32'h0010_8113;
    words[2] = 32'h0020_81B3;
    words[3] = 32'h0000_0013;
    applyStimulus(BANK_INST, 4);
    checkOutput("t1_err_cleared", err, 0);
    checkOutput("t1_busy", busy, 1);
    streamWords(BANK_INST, 4, 32'h0, 0, 1'b0);
    checkOutput("t1_checksum_const", checksum, 32'h0081_036C);
    holdToRun();

    // Data bank with bubbles, also a reload from RUN
    words[0] = 32'hA;
    words[1] = 32'hB;
    words[2] = 32'hC;
    applyStimulus(BANK_DATA, 3);
    checkOutput("t2_cpu_rst_n", cpu_rst_n, 0);
    checkOutput("t2_done", done, 0);
    checkOutput("t2_checksum_clr", checksum, 0);
    streamWords(BANK_DATA, 3, 32'b101001, 6, 1'b0);
    holdToRun();

    // Reject in RUN keeps the CPU running
    applyStimulus(BANK_INST, 257);
    checkOutput("rejrun_err", err, 1);
    checkOutput("rejrun_done", done, 1);
    checkOutput("rejrun_cpu_rst_n", cpu_rst_n, 1);
    checkOutput("rejrun_busy", busy, 0);

    // Reload of two words
    words[0] = 32'h1234_5678;
    words[1] = 32'hF000_0001;
    applyStimulus(BANK_INST, 2);
    checkOutput("reload_cpu_rst_n", cpu_rst_n, 0);
    checkOutput("reload_done", done, 0);
    checkOutput("reload_err", err, 0);
    checkOutput("reload_checksum_clr", checksum, 0);
    streamWords(BANK_INST, 2, 32'h0, 0, 1'b0);
    holdToRun();

    // Full depth with a start pulse mid-load
    for (int i = 0; i < DEPTH; i++) words[i] = (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
    applyStimulus(BANK_INST, 256);
    streamWords(BANK_INST, 256, 32'h0, 0, 1'b1);
    checkOutput("full_err", err, 0);
    holdToRun();

    // Asynchronous reset in the middle of a load
    words[0] = 32'h1111_1111;
    words[1] = 32'h2222_2222;
    applyStimulus(BANK_DATA, 8);
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = words[0];
    step();
    bus_if.s_data = words[1];
    step();
    checkOutput("pre_rst_mem_we", bus_if.mem_we, 2);
    #2;
    rst = 1'b1;
    #1;
    checkAllZero("async_rst");
    bus_if.s_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    checkAllZero("post_rst");

    // Loader usable again after reset
    words[0] = 32'hCAFE_F00D;
    applyStimulus(BANK_DATA, 1);
    streamWords(BANK_DATA, 1, 32'h0, 0, 1'b0);
    holdToRun();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
